// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder instance adds two WIDTH-bit
// operands plus carry-in, LSB first, one bit per clock.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] opa_sr;
   logic [WIDTH-1:0] opb_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             fa_sum;
   logic             fa_carry;

   full_adder u_fa (
      .a     (opa_sr[0]),
      .b     (opb_sr[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New sum bit enters from the MSB side; written as a shift so WIDTH=1 works.
   assign res_next = (res_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_comb begin
      state_next = IDLE;
      load       = 1'b0;
      case (state)
         IDLE: begin
            load       = start;
            state_next = start ? RUN : IDLE;
         end
         RUN: begin
            state_next = (cnt == LAST) ? DONE : RUN;
         end
         DONE: begin
            load       = start;
            state_next = start ? RUN : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Reset has priority; the result registers only change when a RUN finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         carry_q <= 1'b0;
         opa_sr  <= '0;
         opb_sr  <= '0;
         res_sr  <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state <= state_next;
         if (load) begin
            opa_sr  <= a;
            opb_sr  <= b;
            carry_q <= cin;
            cnt     <= '0;
            res_sr  <= '0;
         end else if (state == RUN) begin
            opa_sr  <= opa_sr >> 1;
            opb_sr  <= opb_sr >> 1;
            res_sr  <= res_next;
            carry_q <= fa_carry;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST) begin
               sum  <= res_next;
               cout <= fa_carry;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   // Advance one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for done on the 8-bit instance, counting busy cycles and overlap.
   task automatic wait_done8(output int cycles, output int busy_cycles, output bit overlap);
      cycles      = 0;
      busy_cycles = 0;
      overlap     = 1'b0;
      while (!done8 && cycles < 30) begin
         if (busy8) busy_cycles++;
         if (busy8 && done8) overlap = 1'b1;
         step();
         cycles++;
      end
      if (busy8 && done8) overlap = 1'b1;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      start8 = 1'b1;
      start1 = 1'b1;
      a8     = 8'hFF;
      b8     = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if ({busy8, done8, sum8, cout8} !== 11'h000)
            $display("[TB] FAIL reset8 cyc%0d: busy=%b done=%b sum=%h cout=%b, need 0 0 00 0",
                     i, busy8, done8, sum8, cout8);
         else n_pass++;
         n_checks++;
         if ({busy1, done1, sum1, cout1} !== 4'b0000)
            $display("[TB] FAIL reset1 cyc%0d: busy=%b done=%b sum=%b cout=%b, need 0 0 0 0",
                     i, busy1, done1, sum1, cout1);
         else n_pass++;
      end
      rst    = 1'b0;
      start8 = 1'b0;
      start1 = 1'b0;
      step();
      n_checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0)
         $display("[TB] FAIL idle_after_reset: busy=%b done=%b, need 0 0", busy8, done8);
      else n_pass++;
   endtask

   task automatic test_basic();
      int  cyc, bc;
      bit  ov;
      a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      n_checks++;
      if (sum8 !== 8'h00 || cout8 !== 1'b0)
         $display("[TB] FAIL basic_hold: sum=%h cout=%b, need 00 0", sum8, cout8);
      else n_pass++;
      wait_done8(cyc, bc, ov);
      n_checks++;
      if (cyc !== 8 || bc !== 8 || ov)
         $display("[TB] FAIL basic_latency: cycles=%0d busy=%0d overlap=%b, need 8 8 0", cyc, bc, ov);
      else n_pass++;
      n_checks++;
      if (done8 !== 1'b1 || sum8 !== 8'h7E || cout8 !== 1'b0)
         $display("[TB] FAIL basic_result: done=%b sum=%h cout=%b, need 1 7e 0", done8, sum8, cout8);
      else n_pass++;
      step();
      n_checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h7E)
         $display("[TB] FAIL basic_pulse: done=%b busy=%b sum=%h, need 0 0 7e", done8, busy8, sum8);
      else n_pass++;
   endtask

   task automatic test_overflow();
      int  cyc, bc;
      bit  ov;
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      wait_done8(cyc, bc, ov);
      n_checks++;
      if (cyc !== 8 || sum8 !== 8'h00 || cout8 !== 1'b1)
         $display("[TB] FAIL ovf_ff01: cycles=%0d sum=%h cout=%b, need 8 00 1", cyc, sum8, cout8);
      else n_pass++;
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      if (sum8 !== 8'h00 || cout8 !== 1'b1 || done8 !== 1'b0)
         $display("[TB] FAIL ovf_idle_hold: sum=%h cout=%b done=%b, need 00 1 0", sum8, cout8, done8);
      else n_pass++;
      a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
      step();
      start8 = 1'b0;
      wait_done8(cyc, bc, ov);
      n_checks++;
      if (cyc !== 8 || sum8 !== 8'h00 || cout8 !== 1'b1)
         $display("[TB] FAIL ovf_a55a: cycles=%0d sum=%h cout=%b, need 8 00 1", cyc, sum8, cout8);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      int  cyc, bc;
      bit  ov;
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      step();
      step();
      n_checks++;
      if (busy8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1)
         $display("[TB] FAIL b2b_run_hold: busy=%b sum=%h cout=%b, need 1 00 1", busy8, sum8, cout8);
      else n_pass++;
      start8 = 1'b1; a8 = 8'hFF;
      step();
      start8 = 1'b0;
      wait_done8(cyc, bc, ov);
      n_checks++;
      if (cyc !== 5 || sum8 !== 8'h30 || cout8 !== 1'b0)
         $display("[TB] FAIL b2b_ignore: cycles=%0d sum=%h cout=%b, need 5 30 0", cyc, sum8, cout8);
      else n_pass++;
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      n_checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h30)
         $display("[TB] FAIL b2b_restart: busy=%b done=%b sum=%h, need 1 0 30", busy8, done8, sum8);
      else n_pass++;
      wait_done8(cyc, bc, ov);
      n_checks++;
      if (cyc !== 8 || bc !== 8 || ov || sum8 !== 8'h02 || cout8 !== 1'b0)
         $display("[TB] FAIL b2b_second: cycles=%0d busy=%0d overlap=%b sum=%h cout=%b, need 8 8 0 02 0",
                  cyc, bc, ov, sum8, cout8);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid_run();
      int seen_done;
      a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0)
         $display("[TB] FAIL rst_mid: busy=%b done=%b sum=%h cout=%b, need 0 0 00 0",
                  busy8, done8, sum8, cout8);
      else n_pass++;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done8 || busy8) seen_done++;
      end
      n_checks++;
      if (seen_done !== 0 || sum8 !== 8'h00)
         $display("[TB] FAIL rst_mid_quiet: activity=%0d sum=%h, need 0 00", seen_done, sum8);
      else n_pass++;
   endtask

   task automatic test_width1();
      logic [1:0] expect_tbl [8];
      logic [2:0] abc;
      expect_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      for (int i = 0; i < 8; i++) begin
         abc    = 3'(i);
         a1     = abc[2];
         b1     = abc[1];
         cin1   = abc[0];
         start1 = 1'b1;
         step();
         start1 = 1'b0;
         n_checks++;
         if (busy1 !== 1'b1 || done1 !== 1'b0)
            $display("[TB] FAIL w1_busy abc=%b: busy=%b done=%b, need 1 0", abc, busy1, done1);
         else n_pass++;
         step();
         n_checks++;
         if (done1 !== 1'b1 || busy1 !== 1'b0 || {cout1, sum1} !== expect_tbl[i])
            $display("[TB] FAIL w1_result abc=%b: done=%b busy=%b cout_sum=%b, need 1 0 %b",
                     abc, done1, busy1, {cout1, sum1}, expect_tbl[i]);
         else n_pass++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_reset_mid_run();
      test_width1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
